// File: rtl/logicap_pkg.sv
// Shared definitions for the logic-capture datapath: framer states and header constants.
package logicap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        DATA
    } framer_state_t;

    localparam int          HDR_WORDS     = 3;
    localparam logic [31:0] DEFAULT_MAGIC = 32'h4C434150;

endpackage

// File: rtl/capture_framer.sv
// Wraps one capture's worth of FIFO samples in a 3-word header (magic, trigger
// position, sample count) and streams the framed record toward the DMA engine.
module capture_framer
    import logicap_pkg::*;
#(
    parameter int          size    = 32,
    parameter int          saddr_w = 24,
    parameter logic [31:0] MAGIC   = DEFAULT_MAGIC
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [saddr_w-1:0] buffer_size,
    input  logic [saddr_w-1:0] trigger_pos,
    input  logic [size-1:0]    s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    output logic [size-1:0]    m_tdata,
    output logic               m_tvalid,
    output logic               m_tlast,
    input  logic               m_tready,
    output logic               busy,
    output logic               done,
    output logic               truncated,
    output logic               aborted
);

    framer_state_t      state, state_nxt;
    logic [saddr_w-1:0] len, tpos, count;
    logic [saddr_w-1:0] last_idx;
    logic               truncated_q, done_q, aborted_q;
    logic               data_hs, frame_end;

    assign last_idx  = len - saddr_w'(1);
    assign data_hs   = (state == DATA) && s_tvalid && m_tready;
    assign frame_end = m_tvalid && m_tready && m_tlast;

    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign truncated = truncated_q;
    assign aborted   = aborted_q;

    always_comb begin
        state_nxt = state;
        m_tdata   = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        s_tready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = HDR0;
            end
            HDR0: begin
                m_tvalid = 1'b1;
                m_tdata  = size'(MAGIC);
                if (m_tready) state_nxt = HDR1;
            end
            HDR1: begin
                m_tvalid = 1'b1;
                m_tdata  = size'(tpos);
                if (m_tready) state_nxt = HDR2;
            end
            HDR2: begin
                m_tvalid = 1'b1;
                m_tdata  = size'(len);
                m_tlast  = (len == '0);
                if (m_tready) state_nxt = (len == '0) ? IDLE : DATA;
            end
            DATA: begin
                // Zero-latency pass-through so the FIFO sees the DMA's back-pressure directly.
                m_tvalid = s_tvalid;
                m_tdata  = s_tdata;
                s_tready = m_tready;
                m_tlast  = (count == last_idx) || s_tlast;
                if (data_hs && m_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort suppresses done and truncation even if the aborting cycle also completed the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len         <= '0;
            tpos        <= '0;
            count       <= '0;
            truncated_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    len         <= buffer_size;
                    tpos        <= trigger_pos;
                    count       <= '0;
                    truncated_q <= 1'b0;
                end
            end else if (abort) begin
                aborted_q <= 1'b1;
            end else begin
                if (frame_end) done_q <= 1'b1;
                if (data_hs) begin
                    count <= count + saddr_w'(1);
                    if (s_tlast && count != last_idx) truncated_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_capture_framer.sv
// Scoreboard bench for capture_framer: directed frames push expected words,
// an independent monitor pops and compares every DMA-side handshake.
module tb_capture_framer;

    localparam logic [31:0] MAGIC_W = 32'h4C434150;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort;
    logic [23:0] buffer_size, trigger_pos;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic        busy, done, truncated, aborted;

    int errors = 0;
    int checks = 0;
    int s_tready_hi = 0;
    bit stab_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [32:0] prev_word;
    logic [32:0] sb[$];
    bit timed_out;

    capture_framer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .buffer_size (buffer_size),
        .trigger_pos (trigger_pos),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .busy        (busy),
        .done        (done),
        .truncated   (truncated),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l);
        sb.push_back({l, d});
    endtask

    // Monitor: pops one expected word per DMA handshake; also checks header hold under stall.
    always @(negedge clk) begin
        if (reset_n) begin
            if (s_tready) s_tready_hi++;
            if (stab_en && prev_stall)
                check_output("stall_hold", {31'd0, m_tvalid, m_tlast, m_tdata}, {31'd0, 1'b1, prev_word});
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_word", {31'd0, m_tlast, m_tdata}, 64'hDEAD);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    check_output("word", {31'd0, m_tlast, m_tdata}, {31'd0, e});
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_word  = {m_tlast, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Starts a frame and plays a FIFO source of samples 1..nsrc until busy drops.
    task automatic apply_stimulus(input int nsrc, input int last_idx, input bit toggle_rdy,
                                  input bit gap_valid, input int abort_at, output bit tmo);
        int src_i;
        int cyc;
        bit s_hs;
        bit fired;
        src_i = 0; cyc = 0; fired = 0; tmo = 0;
        m_tready = 1'b1;
        s_tvalid = (nsrc > 0);
        s_tdata  = 32'd1;
        s_tlast  = (last_idx == 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (busy) begin
            if (cyc >= 400) begin
                tmo = 1;
                break;
            end
            @(negedge clk);
            s_hs = s_tvalid && s_tready;
            @(posedge clk); #1;
            cyc++;
            abort = 1'b0;
            if (s_hs) begin
                src_i++;
                s_tvalid = 1'b0;
            end
            if (!s_tvalid && src_i < nsrc && !(gap_valid && (cyc % 3 == 0))) s_tvalid = 1'b1;
            s_tdata  = 32'(src_i + 1);
            s_tlast  = (src_i == last_idx);
            m_tready = toggle_rdy ? !m_tready : 1'b1;
            if (abort_at >= 0 && !fired && src_i == abort_at) begin
                abort = 1'b1;
                fired = 1'b1;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic finish_frame(input string name, input logic exp_done, input logic exp_trunc);
        check_output({name, "_timeout"}, {63'd0, timed_out}, 64'd0);
        check_output({name, "_done"}, {63'd0, done}, {63'd0, exp_done});
        check_output({name, "_trunc"}, {63'd0, truncated}, {63'd0, exp_trunc});
        @(posedge clk); #1;
        check_output({name, "_done_pulse"}, {63'd0, done}, 64'd0);
        check_output({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 0; abort = 0; buffer_size = '0; trigger_pos = '0;
        s_tdata = '0; s_tvalid = 0; s_tlast = 0; m_tready = 0;
        #12;
        check_output("reset_outputs",
                     {25'd0, m_tvalid, m_tlast, s_tready, busy, done, truncated, aborted, m_tdata}, 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame
        buffer_size = 24'd4; trigger_pos = 24'd2;
        push_exp(MAGIC_W, 0); push_exp(32'd2, 0); push_exp(32'd4, 0);
        push_exp(32'd1, 0); push_exp(32'd2, 0); push_exp(32'd3, 0); push_exp(32'd4, 1);
        apply_stimulus(4, -1, 0, 0, -1, timed_out);
        finish_frame("basic", 1'b1, 1'b0);

        // Back-pressure with gapped source, header held while stalled
        stab_en = 1'b1;
        push_exp(MAGIC_W, 0); push_exp(32'd2, 0); push_exp(32'd4, 0);
        push_exp(32'd1, 0); push_exp(32'd2, 0); push_exp(32'd3, 0); push_exp(32'd4, 1);
        apply_stimulus(4, -1, 1, 1, -1, timed_out);
        finish_frame("bp", 1'b1, 1'b0);
        stab_en = 1'b0;

        // Early upstream last
        buffer_size = 24'd8; trigger_pos = 24'd5;
        push_exp(MAGIC_W, 0); push_exp(32'd5, 0); push_exp(32'd8, 0);
        for (int i = 1; i <= 5; i++) push_exp(32'(i), i == 5);
        apply_stimulus(5, 4, 0, 0, -1, timed_out);
        finish_frame("early_last", 1'b1, 1'b1);

        // Zero length
        buffer_size = 24'd0; trigger_pos = 24'd0;
        push_exp(MAGIC_W, 0); push_exp(32'd0, 0); push_exp(32'd0, 1);
        s_tready_hi = 0;
        apply_stimulus(1, -1, 0, 0, -1, timed_out);
        check_output("zero_s_tready", 64'(s_tready_hi), 64'd0);
        finish_frame("zero_len", 1'b1, 1'b0);

        // Abort after 10 data handshakes; the 11th is in flight in the abort cycle
        buffer_size = 24'd128; trigger_pos = 24'd9;
        push_exp(MAGIC_W, 0); push_exp(32'd9, 0); push_exp(32'd128, 0);
        for (int i = 1; i <= 11; i++) push_exp(32'(i), 0);
        apply_stimulus(200, -1, 0, 0, 10, timed_out);
        check_output("abort_timeout", {63'd0, timed_out}, 64'd0);
        check_output("abort_state", {60'd0, aborted, done, m_tvalid, busy}, {60'd0, 4'b1000});
        check_output("abort_s_tready", {63'd0, s_tready}, 64'd0);
        @(posedge clk); #1;
        check_output("abort_pulse", {62'd0, aborted, done}, 64'd0);
        check_output("abort_sb_empty", 64'(sb.size()), 64'd0);

        buffer_size = 24'd2; trigger_pos = 24'd1;
        push_exp(MAGIC_W, 0); push_exp(32'd1, 0); push_exp(32'd2, 0);
        push_exp(32'd1, 0); push_exp(32'd2, 1);
        apply_stimulus(2, -1, 0, 0, -1, timed_out);
        finish_frame("post_abort", 1'b1, 1'b0);

        // Asynchronous reset mid-DATA: header plus two samples reach the DMA first
        buffer_size = 24'd16; trigger_pos = 24'd7;
        s_tdata = 32'hA5A5_0001; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
        push_exp(MAGIC_W, 0); push_exp(32'd7, 0); push_exp(32'd16, 0);
        push_exp(32'hA5A5_0001, 0); push_exp(32'hA5A5_0001, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("async_reset_outputs",
                     {25'd0, m_tvalid, m_tlast, s_tready, busy, done, truncated, aborted, m_tdata}, 64'd0);
        check_output("async_reset_sb", 64'(sb.size()), 64'd0);
        s_tvalid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;

        buffer_size = 24'd1; trigger_pos = 24'd3;
        push_exp(MAGIC_W, 0); push_exp(32'd3, 0); push_exp(32'd1, 0); push_exp(32'd1, 1);
        apply_stimulus(1, -1, 0, 0, -1, timed_out);
        finish_frame("post_reset", 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/capture_framer.md
Name: capture_framer

Overview:
- Downstream of the sample FIFO. Consumes the FIFO master AXI-Stream and emits one framed record per capture toward the DMA engine.
- Each frame is a 3-word header (magic, trigger position, sample count) followed by exactly the latched number of samples. m_tlast is asserted on the final word.
- Truncation on an early upstream tlast, and abort, are reported through status outputs.

Parameters:
- size, 32, sample/stream data width (>= saddr_w, >= 32).
- saddr_w, 24, sample count / address width.
- MAGIC, 32'h4C434150, header word 0 value, truncated/zero-extended to size.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; latch buffer_size/trigger_pos and begin a frame.
- abort  in  1  pulse; terminate the current frame.
- buffer_size  in  saddr_w  samples per frame.
- trigger_pos  in  saddr_w  trigger sample index, copied into the header.
- s_tdata  in  size  FIFO master data.
- s_tvalid  in  1  FIFO master valid.
- s_tlast  in  1  FIFO master last.
- s_tready  out  1  ready to FIFO.
- m_tdata  out  size  frame data to DMA.
- m_tvalid  out  1  frame valid.
- m_tlast  out  1  last word of frame.
- m_tready  in  1  DMA ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on frame completion.
- truncated  out  1  sticky; upstream tlast arrived before the count expired; cleared on start.
- aborted  out  1  one-cycle pulse when abort takes effect.

Behaviour:
- Reset values (reset_n low, async): state=IDLE; all outputs 0; latched registers 0.
- States: IDLE, HDR0, HDR1, HDR2, DATA.
- IDLE:
  - On start: latch buffer_size into len, trigger_pos into tpos; count=0; clear truncated; go to HDR0 next cycle; busy=1 from that cycle.
  - start while busy is ignored.
- HDRn states:
  - m_tvalid=1; s_tready=0.
  - m_tdata: HDR0=MAGIC, HDR1=zero-extended tpos, HDR2=zero-extended len.
  - Advance on m_tvalid&m_tready. Header takes 3 cycles minimum.
- HDR2 with len==0: m_tlast=1 on HDR2; on handshake go to IDLE and pulse done.
- DATA, combinational pass-through (zero latency):
  - m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready.
  - m_tlast = (count==len-1) | s_tlast.
  - On each handshake, count increments (saddr_w-bit, no wrap: len <= 2^saddr_w-1).
- DATA exit:
  - Handshake with count==len-1: go to IDLE, pulse done the following cycle, busy drops the same cycle.
  - Handshake with s_tlast while count<len-1: set truncated, m_tlast=1, go to IDLE, pulse done.
  - s_tlast on the final counted sample is a normal end; truncated stays clear.
- Abort:
  - Abort in any non-IDLE state: next cycle state=IDLE, m_tvalid=0, s_tready=0, aborted pulses, done does not pulse.
  - Abort wins over a same-cycle handshake completion; the in-flight handshake still counts at the DMA.
  - Abort in IDLE: no effect.
  - Abort and start in the same cycle in IDLE: start wins.
- No words are dropped or duplicated under any m_tready/s_tvalid back-pressure pattern.
- m_tdata/m_tlast stay stable while m_tvalid&!m_tready in header states. In DATA they follow upstream, which is AXIS-stable.
- Reset mid-frame: immediate return to IDLE, outputs 0; partial frame abandoned.

Decomposition:
- Shared package logicap_pkg:
  - framer state enum (IDLE/HDR0/HDR1/HDR2/DATA).
  - HDR_WORDS=3.
  - default MAGIC constant.
- No sub-module; single FSM plus counter. Header word mux is inline.

Test Plan:
- Basic frame: buffer_size=4, trigger_pos=2, m_tready=1, FIFO supplies 1,2,3,4 -> output 0x4C434150, 2, 4, 1, 2, 3, 4 with m_tlast only on 4; done pulses once; truncated=0.
- Back-pressure: same frame, m_tready toggling 1010... and s_tvalid gapped -> identical 7-word sequence; header words stable while stalled.
- Early last: buffer_size=8, FIFO gives 5 samples with s_tlast on the 5th -> 3 header + 5 data, m_tlast on 5th, truncated=1, done pulses.
- Zero length: buffer_size=0, trigger_pos=0 -> words MAGIC, 0, 0; m_tlast on the third; s_tready never asserted.
- Abort: buffer_size=128; abort after 10 data handshakes -> next cycle m_tvalid=0, aborted pulse, busy=0, no done. A subsequent start with buffer_size=2 yields a clean 5-word frame.
- Async reset: assert reset_n=0 mid-DATA between clock edges -> all outputs 0 immediately. After release, start with buffer_size=1 produces a correct 4-word frame.
